piso_tx: RTL
============

PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, parallel word width in bits (legal range 2..16).
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 = bit WIDTH-1 sent first, 0 = bit 0 sent first.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port data_in  input  WIDTH  parallel word to serialize, sampled only on an accepted load.
REQ-006 SHALL have port load  input  1  load request, sampled at the clk rising edge.
REQ-007 SHALL have port ready  output  1  high when a load is accepted at the next edge.
REQ-008 SHALL have port sdo  output  1  registered serial data out.
REQ-009 SHALL have port frame  output  1  registered; high exactly while sdo carries a valid frame bit.
REQ-010 SHALL have port done  output  1  registered one-cycle pulse marking frame end.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT and, with PARITY_EN only, PAR; IDLE after reset.
REQ-012 SHALL accept a load only at an edge where load=1 and ready=1; data_in is copied to an internal shift register and the bit counter is cleared.
REQ-013 SHALL drive ready=1 in IDLE and in the done cycle, and ready=0 otherwise.
REQ-014 SHALL ignore load while ready=0: no data capture, frame unaffected.
REQ-015 SHALL, for a load accepted at edge k, present data bit i (serial order per MSB_FIRST) on sdo with frame=1 during cycle k+1+i, for i=0..WIDTH-1.
REQ-016 SHALL pulse done=1 for exactly one cycle, in the cycle after the last frame bit; done SHALL never be 1 together with frame=1.
REQ-017 SHALL support back-to-back frames: a load accepted at the edge ending the done cycle starts the next frame with no extra idle cycle.
REQ-018 SHALL return to IDLE after the done cycle when no new load is accepted.
REQ-019 SHALL hold sdo=0 and frame=0 whenever no frame bit is being sent.
REQ-020 SHALL size the bit counter as ceil(log2(WIDTH+1)) bits, with no wrap inside a frame.
REQ-021 SHALL keep the transmitted word stable when data_in changes after load acceptance.

Reset
REQ-022 SHALL, at any edge with rst=1, set state=IDLE, sdo=0, frame=0, done=0, counter=0, shift register=0; ready SHALL be 1 in the next cycle.
REQ-023 SHALL give rst priority over load; rst asserted mid-frame aborts the frame with no done pulse.
REQ-024 SHALL not accept a load at an edge where rst=1.

Configuration
REQ-025 SHALL use macro PISO_TX_PARITY_EN to compile in a parity bit.
REQ-026 SHALL, with PISO_TX_PARITY_EN defined, enter PAR after the last data bit and send one even-parity bit (XOR of the word) with frame=1 in cycle k+1+WIDTH; done then occurs in cycle k+2+WIDTH.
REQ-027 SHALL, without PISO_TX_PARITY_EN, contain no PAR state and no parity logic; the frame is WIDTH bits long.

Verification
REQ-028 SHALL cover: WIDTH=8, MSB_FIRST=1, data_in=167 (0xA7), load pulse at edge k -> sdo=1,0,1,0,0,1,1,1 in cycles k+1..k+8 with frame=1, done=1 in cycle k+9.
REQ-029 SHALL cover: same stimulus with PISO_TX_PARITY_EN -> 8 data bits, then parity=1 in cycle k+9, done in cycle k+10.
REQ-030 SHALL cover: MSB_FIRST=0, data_in=0xA7 -> sdo=1,1,1,0,0,1,0,1.
REQ-031 SHALL cover: load held high with 0x3C then 0xC3 -> two consecutive frames with no gap, 0x3C bits then 0xC3 bits, two done pulses.
REQ-032 SHALL cover: load=1 with data_in=0xFF during cycle k+3 of a 0xA7 frame -> ignored, frame stays 0xA7.
REQ-033 SHALL cover: rst=1 for one edge in cycle k+4 of a frame -> next cycle sdo=0, frame=0, ready=1, and no done pulse.

Source files
------------

// File: rtl/piso_tx.sv
// piso_tx: parallel-in / serial-out transmitter.
// Accepts a WIDTH-bit word when ready, shifts it out on sdo (MSB or LSB first)
// with frame high for every frame bit, then pulses done for one cycle.
// The done cycle is spent in IDLE, so a new word can be accepted at the edge
// that ends it, giving gap-free back-to-back frames.
// Optional feature: define PISO_TX_PARITY_EN to append one even-parity bit.
module piso_tx #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load,
   output logic             ready,
   output logic             sdo,
   output logic             frame,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef PISO_TX_PARITY_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sreg, sreg_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             sdo_nxt, frame_nxt, done_nxt;
`ifdef PISO_TX_PARITY_EN
   logic             par_bit, par_bit_nxt;
`endif

   // First serial bit of a freshly loaded word.
   function automatic logic first_bit(input logic [WIDTH-1:0] w);
      return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
   endfunction

   // Bit that follows the one currently on sdo; sreg still holds it unshifted.
   function automatic logic next_bit(input logic [WIDTH-1:0] w);
      return (MSB_FIRST != 0) ? w[WIDTH-2] : w[1];
   endfunction

   // Move the shift register one position toward the output end.
   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
   endfunction

   // The done cycle is an IDLE cycle, so ready covers both cases.
   assign ready = (state == IDLE);

   // Next-state and next-output decode; sdo/frame/done default to the idle value.
   always_comb begin
      state_nxt   = state;
      sreg_nxt    = sreg;
      cnt_nxt     = cnt;
      sdo_nxt     = 1'b0;
      frame_nxt   = 1'b0;
      done_nxt    = 1'b0;
`ifdef PISO_TX_PARITY_EN
      par_bit_nxt = par_bit;
`endif
      case (state)
         IDLE: begin
            if (load) begin
               state_nxt   = SHIFT;
               sreg_nxt    = data_in;
               cnt_nxt     = '0;
               sdo_nxt     = first_bit(data_in);
               frame_nxt   = 1'b1;
`ifdef PISO_TX_PARITY_EN
               par_bit_nxt = ^data_in;
`endif
            end
         end
         SHIFT: begin
            if (cnt == LAST_IDX) begin
`ifdef PISO_TX_PARITY_EN
               state_nxt = PAR;
               sdo_nxt   = par_bit;
               frame_nxt = 1'b1;
`else
               state_nxt = IDLE;
               done_nxt  = 1'b1;
`endif
            end else begin
               cnt_nxt   = cnt + CW'(1);
               sreg_nxt  = advance(sreg);
               sdo_nxt   = next_bit(sreg);
               frame_nxt = 1'b1;
            end
         end
`ifdef PISO_TX_PARITY_EN
         PAR: begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // State and registered outputs; reset wins over everything, including load.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         sreg    <= '0;
         cnt     <= '0;
         sdo     <= 1'b0;
         frame   <= 1'b0;
         done    <= 1'b0;
`ifdef PISO_TX_PARITY_EN
         par_bit <= 1'b0;
`endif
      end else begin
         state   <= state_nxt;
         sreg    <= sreg_nxt;
         cnt     <= cnt_nxt;
         sdo     <= sdo_nxt;
         frame   <= frame_nxt;
         done    <= done_nxt;
`ifdef PISO_TX_PARITY_EN
         par_bit <= par_bit_nxt;
`endif
      end
   end

endmodule
